// File: rtl/power_mode_ctrl_pkg.sv
// Shared car constants: mode switch encodings and power FSM state codes.
// The mode codes are used both on the switch input and on the active-mode output.
package power_mode_ctrl_pkg;

   localparam logic [1:0] MODE_SEMI   = 2'b11;
   localparam logic [1:0] MODE_AUTO   = 2'b10;
   localparam logic [1:0] MODE_MANUAL = 2'b01;
   localparam logic [1:0] MODE_OFF    = 2'b00;

   typedef enum logic [2:0] {
      ST_OFF          = 3'b000,
      ST_PRESSING     = 3'b001,
      ST_WAIT_REL_ON  = 3'b010,
      ST_RUN          = 3'b011,
      ST_WAIT_REL_OFF = 3'b100
   } state_t;

endpackage

// File: rtl/power_mode_ctrl_debouncer.sv
// Level debouncer: the output takes a new word only after DEBOUNCE_CYC consecutive
// identical raw samples that differ from the current output.
module power_mode_ctrl_debouncer #(
   parameter int unsigned WIDTH        = 1,
   parameter int unsigned DEBOUNCE_CYC = 2
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] raw,
   output logic [WIDTH-1:0] db
);

   localparam int unsigned CW = $clog2(DEBOUNCE_CYC + 1);

   logic [WIDTH-1:0] cand_q;
   logic [CW-1:0]    cnt_q;
   logic [CW-1:0]    run_len;

   // A sample that differs from the previous candidate restarts the run at one.
   always_comb begin
      run_len = CW'(1);
      if (cnt_q != '0 && raw == cand_q)
         run_len = cnt_q + 1'b1;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         db     <= '0;
         cand_q <= '0;
         cnt_q  <= '0;
      end else if (raw == db) begin
         cand_q <= raw;
         cnt_q  <= '0;
      end else if (run_len >= CW'(DEBOUNCE_CYC)) begin
         db    <= raw;
         cnt_q <= '0;
      end else begin
         cand_q <= raw;
         cnt_q  <= run_len;
      end
   end

endmodule

// File: rtl/power_mode_ctrl.sv
// Car power/mode controller: long press powers on, any press or a break request
// powers off, and the debounced mode switch is passed through only while running.
module power_mode_ctrl
   import power_mode_ctrl_pkg::*;
#(
   parameter int unsigned DEBOUNCE_CYC   = 2,
   parameter int unsigned LONG_PRESS_CYC = 100
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       power,
   input  logic [1:0] mode_selection,
   input  logic       brk,           // fault request; "break" is a reserved word
   output logic [1:0] mode,
   output logic       powered,
   output logic [2:0] state
);

   localparam int unsigned   CW        = $clog2(LONG_PRESS_CYC) + 1;
   localparam logic [CW-1:0] HOLD_LAST = CW'(LONG_PRESS_CYC - 1);

   logic          pwr_db;
   logic          pwr_prev_q;
   logic          pwr_rise;
   logic [1:0]    sel_db;
   state_t        state_q;
   state_t        state_nxt;
   logic [CW-1:0] hold_q;
   logic [CW-1:0] hold_nxt;
   logic [1:0]    mode_nxt;

   power_mode_ctrl_debouncer #(.WIDTH(1), .DEBOUNCE_CYC(DEBOUNCE_CYC)) u_pwr_db (
      .clk   (clk),
      .reset (reset),
      .raw   (power),
      .db    (pwr_db)
   );

   power_mode_ctrl_debouncer #(.WIDTH(2), .DEBOUNCE_CYC(DEBOUNCE_CYC)) u_sel_db (
      .clk   (clk),
      .reset (reset),
      .raw   (mode_selection),
      .db    (sel_db)
   );

   assign pwr_rise = pwr_db & ~pwr_prev_q;

   always_comb begin
      state_nxt = state_q;
      hold_nxt  = hold_q;
      case (state_q)
         ST_OFF: begin
            if (pwr_rise && !brk) begin
               state_nxt = ST_PRESSING;
               hold_nxt  = '0;
            end
         end
         ST_PRESSING: begin
            if (brk || !pwr_db)
               state_nxt = ST_OFF;
            else if (hold_q == HOLD_LAST)
               state_nxt = ST_WAIT_REL_ON;
            else if (hold_q != '1)
               hold_nxt = hold_q + 1'b1;
         end
         ST_WAIT_REL_ON: begin
            if (brk)
               state_nxt = ST_OFF;
            else if (!pwr_db)
               state_nxt = ST_RUN;
         end
         ST_RUN: begin
            if (brk)
               state_nxt = pwr_db ? ST_WAIT_REL_OFF : ST_OFF;
            else if (pwr_rise)
               state_nxt = ST_WAIT_REL_OFF;
         end
         ST_WAIT_REL_OFF: begin
            if (!pwr_db)
               state_nxt = ST_OFF;
         end
         default: state_nxt = ST_OFF;
      endcase
      // Outputs follow the next state so power-off blanks mode on the same edge.
      mode_nxt = (state_nxt == ST_RUN) ? sel_db : MODE_OFF;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q    <= ST_OFF;
         hold_q     <= '0;
         pwr_prev_q <= 1'b0;
         mode       <= MODE_OFF;
         powered    <= 1'b0;
      end else begin
         state_q    <= state_nxt;
         hold_q     <= hold_nxt;
         pwr_prev_q <= pwr_db;
         mode       <= mode_nxt;
         powered    <= (state_nxt == ST_RUN);
      end
   end

   assign state = state_q;

endmodule

// File: tb/tb_power_mode_ctrl.sv
// Bench for power_mode_ctrl: directed scenarios plus random button/switch/break
// traffic, all checked every cycle against a behavioural model of the rules.
module tb_power_mode_ctrl;

   localparam int D = 2;
   localparam int L = 100;

   localparam int IDLE    = 0;
   localparam int HOLDING = 1;
   localparam int ARMED   = 2;
   localparam int ON      = 3;
   localparam int RELEASE = 4;

   logic       clk = 1'b0;
   logic       reset;
   logic       power;
   logic [1:0] mode_selection;
   logic       brk;
   logic [1:0] mode;
   logic       powered;
   logic [2:0] state;

   int vectors    = 0;
   int miscompares = 0;

   int         m_phase;
   int         m_held;
   logic       m_pdb, m_pprev;
   logic [1:0] m_sdb;
   logic       p_hist[$];
   logic [1:0] s_hist[$];
   logic [2:0] e_state;
   logic [1:0] e_mode;
   logic       e_pow;

   power_mode_ctrl #(.DEBOUNCE_CYC(D), .LONG_PRESS_CYC(L)) dut (
      .clk            (clk),
      .reset          (reset),
      .power          (power),
      .mode_selection (mode_selection),
      .brk            (brk),
      .mode           (mode),
      .powered        (powered),
      .state          (state)
   );

   always #5 clk = ~clk;

   function automatic logic [2:0] code_of(input int ph);
      case (ph)
         HOLDING: return 3'b001;
         ARMED:   return 3'b010;
         ON:      return 3'b011;
         RELEASE: return 3'b100;
         default: return 3'b000;
      endcase
   endfunction

   task automatic model_reset();
      m_phase = IDLE; m_held = 0;
      m_pdb = 1'b0; m_pprev = 1'b0; m_sdb = 2'b00;
      p_hist.delete(); s_hist.delete();
      e_state = 3'b000; e_mode = 2'b00; e_pow = 1'b0;
   endtask

   task automatic model_step(input logic p, input logic [1:0] s, input logic b);
      logic rise;
      int   nxt;
      bit   same;
      rise = m_pdb && !m_pprev;
      nxt  = m_phase;
      case (m_phase)
         IDLE:    if (rise && !b) begin nxt = HOLDING; m_held = 1; end
         HOLDING: begin
            if (b || !m_pdb) nxt = IDLE;
            else begin
               m_held++;
               if (m_held == L + 1) nxt = ARMED;
            end
         end
         ARMED:   if (b) nxt = IDLE; else if (!m_pdb) nxt = ON;
         ON:      if (b) nxt = m_pdb ? RELEASE : IDLE; else if (rise) nxt = RELEASE;
         RELEASE: if (!m_pdb) nxt = IDLE;
         default: nxt = IDLE;
      endcase
      e_state = code_of(nxt);
      e_pow   = (nxt == ON);
      e_mode  = (nxt == ON) ? m_sdb : 2'b00;
      m_phase = nxt;
      m_pprev = m_pdb;
      p_hist.push_back(p);
      if (p_hist.size() > D) void'(p_hist.pop_front());
      if (p_hist.size() == D) begin
         same = 1;
         foreach (p_hist[i]) if (p_hist[i] !== p) same = 0;
         if (same) m_pdb = p;
      end
      s_hist.push_back(s);
      if (s_hist.size() > D) void'(s_hist.pop_front());
      if (s_hist.size() == D) begin
         same = 1;
         foreach (s_hist[i]) if (s_hist[i] !== s) same = 0;
         if (same) m_sdb = s;
      end
   endtask

   // Drive inputs away from the edge, advance one clock, update the model, settle.
   task automatic tick(input logic p, input logic [1:0] s, input logic b);
      power = p; mode_selection = s; brk = b;
      @(posedge clk);
      model_step(p, s, b);
      #1;
   endtask

   task automatic async_reset_pulse();
      #2;
      reset = 1'b0;
      #1;
      model_reset();
      #1;
      reset = 1'b1;
   endtask

   task automatic test_reset();
      reset = 1'b0; power = 1'b0; mode_selection = 2'b00; brk = 1'b0;
      model_reset();
      #23;
      vectors++;
      if ({state, mode, powered} !== 6'b000_00_0) begin
         miscompares++;
         $display("FAIL reset_state: state/mode/powered = %b/%b/%b, expected 000/00/0", state, mode, powered);
      end
      reset = 1'b1;
      tick(1'b1, 2'b10, 1'b0);
      vectors++;
      if ({state, mode, powered} !== 6'b000_00_0) begin
         miscompares++;
         $display("FAIL first_edge: state/mode/powered = %b/%b/%b, expected 000/00/0", state, mode, powered);
      end
   endtask

   task automatic test_power_on();
      int first_armed = -1;
      for (int i = 0; i < 160; i++) begin
         tick(i < 150, 2'b10, 1'b0);
         vectors++;
         if ({state, mode, powered} !== {e_state, e_mode, e_pow}) begin
            miscompares++;
            $display("FAIL power_on step %0d: state/mode/powered = %b/%b/%b, expected %b/%b/%b",
                     i, state, mode, powered, e_state, e_mode, e_pow);
         end
         if (state == 3'b010 && first_armed < 0) first_armed = i;
      end
      vectors++;
      if (first_armed < 98 || first_armed > 104) begin
         miscompares++;
         $display("FAIL power_on_latency: reached 010 at step %0d, expected 98..104", first_armed);
      end
      vectors++;
      if ({state, mode, powered} !== 6'b011_10_1) begin
         miscompares++;
         $display("FAIL power_on_final: state/mode/powered = %b/%b/%b, expected 011/10/1", state, mode, powered);
      end
   endtask

   task automatic test_power_off();
      logic pat[$] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1,
                       1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
      foreach (pat[i]) begin
         tick(pat[i], 2'b10, 1'b0);
         vectors++;
         if ({state, mode, powered} !== {e_state, e_mode, e_pow}) begin
            miscompares++;
            $display("FAIL power_off step %0d: state/mode/powered = %b/%b/%b, expected %b/%b/%b",
                     i, state, mode, powered, e_state, e_mode, e_pow);
         end
         if (i == 5) begin
            vectors++;
            if (state !== 3'b011) begin
               miscompares++;
               $display("FAIL glitch_ignored: state = %b, expected 011", state);
            end
         end
         if (i == 8) begin
            vectors++;
            if ({state, mode, powered} !== 6'b100_00_0) begin
               miscompares++;
               $display("FAIL press_off: state/mode/powered = %b/%b/%b, expected 100/00/0", state, mode, powered);
            end
         end
      end
      vectors++;
      if (state !== 3'b000) begin
         miscompares++;
         $display("FAIL off_after_release: state = %b, expected 000", state);
      end
   endtask

   task automatic test_short_press();
      bit mode_seen = 0;
      for (int i = 0; i < 60; i++) begin
         tick(i < 50, 2'b11, 1'b0);
         vectors++;
         if ({state, mode, powered} !== {e_state, e_mode, e_pow}) begin
            miscompares++;
            $display("FAIL short_press step %0d: state/mode/powered = %b/%b/%b, expected %b/%b/%b",
                     i, state, mode, powered, e_state, e_mode, e_pow);
         end
         if (mode !== 2'b00) mode_seen = 1;
      end
      vectors++;
      if (mode_seen || state !== 3'b000) begin
         miscompares++;
         $display("FAIL short_press_ignored: state = %b, nonzero mode seen = %0d, expected 000 and 0", state, mode_seen);
      end
   endtask

   task automatic test_break();
      for (int i = 0; i < 320; i++) begin
         if (i < 110)      tick(1'b1, 2'b01, 1'b0);
         else if (i < 115) tick(1'b0, 2'b01, 1'b0);
         else if (i == 115) tick(1'b0, 2'b01, 1'b1);
         else              tick(i < 316, 2'b01, 1'b0);
         vectors++;
         if ({state, mode, powered} !== {e_state, e_mode, e_pow}) begin
            miscompares++;
            $display("FAIL break step %0d: state/mode/powered = %b/%b/%b, expected %b/%b/%b",
                     i, state, mode, powered, e_state, e_mode, e_pow);
         end
         if (i == 114 || i == 115) begin
            vectors++;
            if ({state, mode} !== ((i == 114) ? 5'b011_01 : 5'b000_00)) begin
               miscompares++;
               $display("FAIL break_edge step %0d: state/mode = %b/%b", i, state, mode);
            end
         end
      end
      vectors++;
      if ({state, mode, powered} !== 6'b011_01_1) begin
         miscompares++;
         $display("FAIL restart_after_break: state/mode/powered = %b/%b/%b, expected 011/01/1", state, mode, powered);
      end
   endtask

   task automatic test_bounce();
      logic [1:0] pat[$] = '{2'b11, 2'b10, 2'b11, 2'b11, 2'b11, 2'b11};
      bit saw_auto = 0;
      foreach (pat[i]) begin
         tick(1'b0, pat[i], 1'b0);
         vectors++;
         if ({state, mode, powered} !== {e_state, e_mode, e_pow}) begin
            miscompares++;
            $display("FAIL bounce step %0d: state/mode/powered = %b/%b/%b, expected %b/%b/%b",
                     i, state, mode, powered, e_state, e_mode, e_pow);
         end
         if (mode === 2'b10) saw_auto = 1;
      end
      vectors++;
      if (saw_auto || mode !== 2'b11) begin
         miscompares++;
         $display("FAIL bounce_direct: mode = %b, saw 10 = %0d, expected 11 and 0", mode, saw_auto);
      end
   endtask

   task automatic test_async_reset();
      #2;
      reset = 1'b0;
      #1;
      vectors++;
      if ({state, mode, powered} !== 6'b000_00_0) begin
         miscompares++;
         $display("FAIL async_reset: state/mode/powered = %b/%b/%b, expected 000/00/0", state, mode, powered);
      end
      model_reset();
      #1;
      reset = 1'b1;
      for (int i = 0; i < 4; i++) begin
         tick(1'b0, 2'b11, 1'b0);
         vectors++;
         if ({state, mode, powered} !== {e_state, e_mode, e_pow}) begin
            miscompares++;
            $display("FAIL post_reset step %0d: state/mode/powered = %b/%b/%b, expected %b/%b/%b",
                     i, state, mode, powered, e_state, e_mode, e_pow);
         end
      end
   endtask

   task automatic test_reset_mid_press();
      int first_armed = -1;
      for (int i = 0; i < 60; i++) tick(1'b1, 2'b10, 1'b0);
      power = 1'b1;
      async_reset_pulse();
      for (int i = 0; i < 120; i++) begin
         tick(i < 110, 2'b10, 1'b0);
         vectors++;
         if ({state, mode, powered} !== {e_state, e_mode, e_pow}) begin
            miscompares++;
            $display("FAIL mid_press step %0d: state/mode/powered = %b/%b/%b, expected %b/%b/%b",
                     i, state, mode, powered, e_state, e_mode, e_pow);
         end
         if (state == 3'b010 && first_armed < 0) first_armed = i;
      end
      vectors++;
      if (first_armed < 100) begin
         miscompares++;
         $display("FAIL mid_press_full_hold: reached 010 at step %0d, expected >= 100", first_armed);
      end
   endtask

   task automatic test_random();
      logic       p = 1'b0;
      logic [1:0] s = 2'b00;
      int         burst = 0;
      for (int i = 0; i < 4000; i++) begin
         if (burst == 0) begin
            p = ~p;
            burst = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : $urandom_range(1, 140);
         end
         burst--;
         if ($urandom_range(0, 24) == 0) s = 2'($urandom_range(0, 3));
         tick(p, s, $urandom_range(0, 79) == 0);
         vectors++;
         if ({state, mode, powered} !== {e_state, e_mode, e_pow}) begin
            miscompares++;
            $display("FAIL random step %0d: state/mode/powered = %b/%b/%b, expected %b/%b/%b",
                     i, state, mode, powered, e_state, e_mode, e_pow);
         end
      end
   endtask

   initial begin
      test_reset();
      test_power_on();
      test_power_off();
      test_short_press();
      test_break();
      test_bounce();
      test_async_reset();
      test_reset_mid_press();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1);
   end

endmodule

// File: doc/power_mode_ctrl.md
POWER_MODE_CTRL -- requirements
Module: power_mode_ctrl

Interface
REQ-001 Parameter DEBOUNCE_CYC, default 2: consecutive equal samples required to accept a new power or mode_selection level.
REQ-002 Parameter LONG_PRESS_CYC, default 100: debounced-high power cycles for power-on (1 s at the 100 Hz divided clock).
REQ-003 clk  input  1  divided system clock (out_clk of clock_diviser); single clock domain.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 power  input  1  raw power push-button level, high = pressed.
REQ-006 mode_selection  input  2  raw switch level: 11 semi, 10 auto, 01 manual, 00 off.
REQ-007 break  input  1  one-cycle-or-longer fault request from the manual driving block; forces shutdown.
REQ-008 mode  output  2  registered active mode, same encoding as mode_selection; 00 whenever not powered.
REQ-009 powered  output  1  registered, high in state RUN only.
REQ-010 state  output  3  registered FSM state code for debug LEDs.

Function
REQ-011 Power input SHALL be debounced: pwr_db changes only after DEBOUNCE_CYC consecutive samples at the new level; its initial value is 0.
REQ-012 mode_selection SHALL be debounced as a 2-bit word: sel_db updates only after DEBOUNCE_CYC consecutive identical samples; initial value 00.
REQ-013 FSM states and codes: OFF=000, PRESSING=001, WAIT_REL_ON=010, RUN=011, WAIT_REL_OFF=100; other codes return to OFF next cycle.
REQ-014 OFF: mode=00, powered=0; pwr_db rising -> PRESSING with hold counter cleared to 0.
REQ-015 PRESSING: counter increments each cycle while pwr_db=1; pwr_db=0 before reaching LONG_PRESS_CYC -> OFF (short press from OFF is ignored).
REQ-016 PRESSING: counter reaching LONG_PRESS_CYC-1 with pwr_db=1 -> WAIT_REL_ON; counter SHALL saturate, never wrap.
REQ-017 WAIT_REL_ON: mode stays 00; pwr_db=0 -> RUN.
REQ-018 RUN: powered=1; mode SHALL equal sel_db, registered, so a debounced switch change is visible one cycle after sel_db updates.
REQ-019 RUN: pwr_db rising (any press length) -> WAIT_REL_OFF; mode forced to 00 and powered=0 in the same transition cycle.
REQ-020 WAIT_REL_OFF: mode=00; pwr_db=0 -> OFF; power held indefinitely SHALL NOT restart the car.
REQ-021 break=1 in RUN -> WAIT_REL_OFF if pwr_db=1, else OFF; mode=00 on the next clock edge.
REQ-022 break=1 in PRESSING or WAIT_REL_ON -> OFF.
REQ-023 Simultaneous break and power edge in any state: break has priority.
REQ-024 sel_db=00 in RUN keeps powered=1 with mode=00 (idle, powered).
REQ-025 Counter width SHALL be $clog2(LONG_PRESS_CYC)+1 bits.

Reset
REQ-026 reset low SHALL asynchronously force state=OFF, mode=00, powered=0, counters 0, pwr_db=0, sel_db=00.
REQ-027 Reset release mid-press SHALL require the full LONG_PRESS_CYC debounced hold again.
REQ-028 No output SHALL change on the first active clock edge after reset release.

Structure
REQ-029 Mode encodings (MODE_SEMI/AUTO/MANUAL/OFF) and FSM state codes SHALL live in the shared car constants package, also used by the top-level mux selects.
REQ-030 One sub-module, debouncer (parameterised width and DEBOUNCE_CYC), SHALL be instantiated twice: power (width 1) and mode_selection (width 2).
REQ-031 The top level SHALL drive its mode wire and the debug LEDs from this block's mode and state outputs.

Verification
REQ-032 reset low, power=1 held 150 cycles after release, mode_selection=10 -> state 001 then 010 at about cycle 102, mode=00 until release, then state=011, mode=10, powered=1.
REQ-033 From OFF, power pulse 50 cycles -> returns to OFF, mode=00 throughout.
REQ-034 In RUN, 1-cycle power glitch -> ignored; 5-cycle press -> mode=00 next edge after pwr_db rise, state 100, OFF after release.
REQ-035 In RUN mode=01, break pulse 1 cycle with power=0 -> mode=00, state=000 next edge; then power held 200 cycles -> RUN again.
REQ-036 In RUN, mode_selection 01->11 with 1-cycle bounce to 10 -> mode goes directly 01->11, never 10.
REQ-037 reset asserted in RUN mid-clock -> mode=00, powered=0 immediately, without waiting for a clock edge.
